// File: rtl/logic_gate_seq.sv
// Bit-serial logic unit: one 1-bit gate slice walks a WIDTH-bit word LSB first.
// Define LOGIC_GATE_SEQ_PARALLEL_EN to use WIDTH slices and finish RUN in one cycle.
module logic_gate_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; in_ready only in IDLE, out_valid only in DONE, so they never
  // complete on the same edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_lat;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic             accept;
  logic             run_last;

  function automatic logic gate_bit(input logic [2:0] g_op, input logic x, input logic y);
    logic r;
    case (g_op)
      3'd0:    r = ~x;
      3'd1:    r = x & y;
      3'd2:    r = ~(x & y);
      3'd3:    r = x | y;
      3'd4:    r = ~(x | y);
      3'd5:    r = x ^ y;
      3'd6:    r = ~(x ^ y);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

`ifdef LOGIC_GATE_SEQ_PARALLEL_EN
  logic [WIDTH-1:0] run_word;

  always_comb begin
    run_word = '0;
    for (int i = 0; i < WIDTH; i++) begin
      run_word[i] = gate_bit(op_lat, a_lat[i], b_lat[i]);
    end
  end

  assign run_last = 1'b1;
`else
  logic run_bit;

  assign run_bit  = gate_bit(op_lat, a_lat[cnt], b_lat[cnt]);
  assign run_last = (cnt == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (run_last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_lat <= '0;
      a_lat  <= '0;
      b_lat  <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_lat <= op;
            a_lat  <= a;
            b_lat  <= b;
            cnt    <= '0;
            result <= '0;
            err    <= (op == 3'd7);
          end
        end
        RUN: begin
`ifdef LOGIC_GATE_SEQ_PARALLEL_EN
          result <= run_word;
`else
          result[cnt] <= run_bit;
          // Counter stops at the top bit instead of wrapping.
          if (!run_last) cnt <= cnt + CNT_W'(1);
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_gate_seq.sv
// Directed bench for logic_gate_seq: hand-computed vectors, latency, backpressure and reset.
module tb_logic_gate_seq;

  localparam int WIDTH = 8;
`ifdef LOGIC_GATE_SEQ_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = WIDTH;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             err;

  int errors;
  int checks;

  logic_gate_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Drivers and checkers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a command for one accepting edge, then scramble the inputs.
  task automatic send(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    check_bit({tag, "_ready_before"}, in_ready, 1'b1);
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    op       = ~o;
    a        = ~x;
    b        = ~y;
    check_bit({tag, "_busy"}, in_ready, 1'b0);
  endtask

  task automatic wait_result(input string tag, input logic [WIDTH-1:0] exp_res, input logic exp_err);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check_int({tag, "_latency"}, n, LAT);
    check_word({tag, "_result"}, result, exp_res);
    check_bit({tag, "_err"}, err, exp_err);
  endtask

  task automatic take(input string tag, input logic [WIDTH-1:0] exp_res);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_bit({tag, "_valid_drop"}, out_valid, 1'b0);
    check_bit({tag, "_idle_ready"}, in_ready, 1'b1);
    check_word({tag, "_held"}, result, exp_res);
  endtask

  initial begin
    int seen;
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    op        = 3'd1;
    a         = 8'hC3;
    b         = 8'hA5;

    // Reset with in_valid held high
    step();
    step();
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_word("rst_result", result, 8'h00);
    check_bit("rst_err", err, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();

    // Gate vectors
    send("and", 3'd1, 8'hC3, 8'hA5);
    wait_result("and", 8'h81, 1'b0);
    take("and", 8'h81);

    send("xor", 3'd5, 8'hC3, 8'hA5);
    wait_result("xor", 8'h66, 1'b0);
    take("xor", 8'h66);

    send("nor", 3'd4, 8'hC3, 8'hA5);
    wait_result("nor", 8'h18, 1'b0);
    take("nor", 8'h18);

    send("xnor", 3'd6, 8'hC3, 8'hA5);
    wait_result("xnor", 8'h99, 1'b0);
    take("xnor", 8'h99);

    send("not", 3'd0, 8'hC3, 8'hFF);
    wait_result("not", 8'h3C, 1'b0);
    take("not", 8'h3C);

    send("rsv", 3'd7, 8'hFF, 8'hFF);
    wait_result("rsv", 8'h00, 1'b1);
    take("rsv", 8'h00);
    check_bit("rsv_err_held", err, 1'b1);

    // Backpressure: stall in DONE while a second command waits
    send("bp", 3'd1, 8'hC3, 8'hA5);
    wait_result("bp", 8'h81, 1'b0);
    op       = 3'd5;
    a        = 8'hC3;
    b        = 8'hA5;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_word("bp_hold_result", result, 8'h81);
      check_bit("bp_hold_ready", in_ready, 1'b0);
      check_bit("bp_hold_valid", out_valid, 1'b1);
    end
    // out_ready and in_valid together: only the output side completes
    take("bp_release", 8'h81);
    step();
    in_valid = 1'b0;
    check_bit("bp_second_busy", in_ready, 1'b0);
    wait_result("bp_second", 8'h66, 1'b0);
    take("bp_second", 8'h66);

    // Reset while RUN is in flight
    send("mid", 3'd2, 8'hC3, 8'hA5);
    if (LAT > 4) begin
      repeat (3) step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_bit("mid_rst_ready", in_ready, 1'b1);
    check_bit("mid_rst_valid", out_valid, 1'b0);
    check_word("mid_rst_result", result, 8'h00);
    check_bit("mid_rst_err", err, 1'b0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    check_int("mid_no_valid", seen, 0);

    send("or", 3'd3, 8'h0F, 8'h30);
    wait_result("or", 8'h3F, 1'b0);
    take("or", 8'h3F);

    send("nand", 3'd2, 8'hC3, 8'hA5);
    wait_result("nand", 8'h7E, 1'b0);
    take("nand", 8'h7E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
